// File: rtl/riscv_muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define RISCV_FAST_MUL_EN to replace the iterative multiply with a single-cycle product.
module riscv_muldiv_unit #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic            op_w,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CNT_W-1:0] LastFull = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] LastWord = CNT_W'(31);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        funct3_q;
    logic              is_w_q;
    logic              neg_q;
    logic              spec_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] opnd_q;
    logic [XLEN-1:0]   sh_q;

    // Issue-time decode of the incoming op
    logic              is_w, is_div, a_signed, b_signed, sa, sb, b_zero, ovf, neg, fast_mul;
    logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b, spec_val;
    logic [2*XLEN-1:0] fast_prod;

    always_comb begin
        is_w     = (XLEN == 64) && op_w;
        is_div   = funct3[2];
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        if (!is_w) begin
            a_ext = operand_a;
            b_ext = operand_b;
        end else begin
            if (a_signed) a_ext = XLEN'($signed(operand_a[31:0]));
            else          a_ext = XLEN'(operand_a[31:0]);
            if (b_signed) b_ext = XLEN'($signed(operand_b[31:0]));
            else          b_ext = XLEN'(operand_b[31:0]);
        end
        sa     = a_signed & a_ext[XLEN-1];
        sb     = b_signed & b_ext[XLEN-1];
        mag_a  = sa ? -a_ext : a_ext;
        mag_b  = sb ? -b_ext : b_ext;
        b_zero = (b_ext == '0);
        ovf    = is_div && a_signed && (b_ext == '1) &&
                 (is_w ? (operand_a[31:0] == 32'h8000_0000)
                       : (operand_a == {1'b1, {(XLEN-1){1'b0}}}));
        // Remainder takes the dividend's sign; product and quotient take sa^sb
        neg    = (is_div && funct3[1]) ? sa : (sa ^ sb);
        if (b_zero) spec_val = funct3[1] ? a_ext : '1;
        else        spec_val = funct3[1] ? '0 : a_ext;
`ifdef RISCV_FAST_MUL_EN
        fast_mul  = !is_div;
        fast_prod = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
`else
        fast_mul  = 1'b0;
        fast_prod = '0;
`endif
    end

    // Restoring-divide step: shift next dividend bit into the partial remainder
    logic [XLEN:0]   rem_sh;
    logic            sub_ok;
    logic [XLEN-1:0] diff;

    always_comb begin
        rem_sh = {acc_q[XLEN-1:0], sh_q[XLEN-1]};
        sub_ok = rem_sh >= {1'b0, opnd_q[XLEN-1:0]};
        diff   = rem_sh[XLEN-1:0] - opnd_q[XLEN-1:0];
    end

    // Final sign fix-up and word-op sign extension
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, res_raw, fin;

    always_comb begin
        prod_s = neg_q ? -acc_q : acc_q;
        quo_s  = neg_q ? -sh_q : sh_q;
        rem_s  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        if (spec_q)              res_raw = sh_q;
        else if (!funct3_q[2])   res_raw = (funct3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0]
                                                                 : prod_s[2*XLEN-1:XLEN];
        else                     res_raw = funct3_q[1] ? rem_s : quo_s;
        fin = is_w_q ? XLEN'($signed(res_raw[31:0])) : res_raw;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            done     <= 1'b0;
            result   <= '0;
            funct3_q <= '0;
            is_w_q   <= 1'b0;
            neg_q    <= 1'b0;
            spec_q   <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            sh_q     <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            funct3_q <= funct3;
                            is_w_q   <= is_w;
                            neg_q    <= neg;
                            cnt_q    <= '0;
                            spec_q   <= 1'b0;
                            acc_q    <= '0;
                            if (is_div && (b_zero || ovf)) begin
                                spec_q  <= 1'b1;
                                sh_q    <= spec_val;
                                state_q <= StDone;
                            end else if (fast_mul) begin
                                acc_q   <= fast_prod;
                                state_q <= StDone;
                            end else if (is_div) begin
                                opnd_q  <= {{XLEN{1'b0}}, mag_b};
                                // Align a 32-bit dividend to the top so N=32 steps consume it
                                sh_q    <= is_w ? (mag_a << (XLEN - 32)) : mag_a;
                                state_q <= StRun;
                            end else begin
                                opnd_q  <= {{XLEN{1'b0}}, mag_a};
                                sh_q    <= mag_b;
                                state_q <= StRun;
                            end
                        end
                    end
                    StRun: begin
                        if (funct3_q[2]) begin
                            if (sub_ok) begin
                                acc_q <= {{XLEN{1'b0}}, diff};
                                sh_q  <= {sh_q[XLEN-2:0], 1'b1};
                            end else begin
                                acc_q <= {{XLEN{1'b0}}, rem_sh[XLEN-1:0]};
                                sh_q  <= {sh_q[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            if (sh_q[0]) acc_q <= acc_q + opnd_q;
                            opnd_q <= opnd_q << 1;
                            sh_q   <= sh_q >> 1;
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == (is_w_q ? LastWord : LastFull)) state_q <= StDone;
                    end
                    StDone: begin
                        done    <= 1'b1;
                        result  <= fin;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign busy = (state_q != StIdle);

endmodule
